// File: rtl/rs_issue_scheduler_pkg.sv
// Shared scheduler constants: default sizing, slot-index width helper and slot-index type.
package rs_pkg;
    localparam int unsigned DEF_NUM_SLOTS = 8;
    localparam int unsigned DEF_NUM_FU    = 4;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_SEL_W = sel_width(DEF_NUM_SLOTS);

    typedef logic [DEF_SEL_W-1:0] slot_idx_t;
endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Slot-array / front-end / FU-side signal bundle for the issue scheduler.
interface rs_issue_scheduler_if import rs_pkg::*; #(
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned NUM_FU    = DEF_NUM_FU,
    parameter int unsigned SEL_W     = sel_width(NUM_SLOTS)
);
    logic [NUM_SLOTS-1:0]          slot_busy;
    logic [NUM_SLOTS-1:0]          slot_ready;
    logic                          dispatch_valid;
    logic                          dispatch_ready;
    logic [NUM_SLOTS-1:0]          alloc_wr;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_FU-1:0]             issue_valid;
    logic [NUM_FU-1:0][SEL_W-1:0]  issue_sel;
    logic [NUM_SLOTS-1:0]          slot_issued;

    modport master (
        output slot_busy, slot_ready, dispatch_valid, fu_ready,
        input  dispatch_ready, alloc_wr, issue_valid, issue_sel, slot_issued
    );

    modport slave (
        input  slot_busy, slot_ready, dispatch_valid, fu_ready,
        output dispatch_ready, alloc_wr, issue_valid, issue_sel, slot_issued
    );
endinterface

// File: rtl/rs_issue_scheduler_rr_picker.sv
// Find-first-set over req, searching upward from ptr with wrap-around.
module rr_picker import rs_pkg::*; #(
    parameter int unsigned N = DEF_NUM_SLOTS,
    parameter int unsigned W = sel_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    always_comb begin
        int unsigned pos;
        pos   = 0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = int'(unsigned'(ptr)) + i;
            if (pos >= N) pos = pos - N;
            if (!found && req[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end
endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station issue scheduler: free-slot allocation plus round-robin multi-issue to FUs.
// Optional RS_SCHED_PERF_EN adds saturating issue/stall performance counters.
module rs_issue_scheduler import rs_pkg::*; #(
    parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int unsigned NUM_FU    = DEF_NUM_FU,
    parameter int unsigned SEL_W     = sel_width(NUM_SLOTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    rs_issue_scheduler_if.slave bus
`ifdef RS_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_issue_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);
    logic [NUM_SLOTS-1:0] issue_pend, alloc_pend;
    logic [NUM_SLOTS-1:0] free_slots, candidates, grant_mask;
    logic [SEL_W-1:0]     rr_ptr, rr_next;
    logic [NUM_SLOTS-1:0] remain [NUM_FU+1];
    logic [SEL_W-1:0]     pick_idx [NUM_FU];
    logic                 found_fu [NUM_FU];
    logic                 grant_fu [NUM_FU];

    assign free_slots         = ~bus.slot_busy & ~alloc_pend;
    assign bus.dispatch_ready = |free_slots;
    assign bus.alloc_wr       = bus.dispatch_valid ? (free_slots & (-free_slots)) : '0;

    assign candidates = bus.slot_ready & bus.slot_busy & ~issue_pend;

    // Each ready FU takes the next candidate in round-robin order from what earlier FUs left.
    assign remain[0] = candidates;
    for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
        rr_picker #(.N(NUM_SLOTS), .W(SEL_W)) u_pick (
            .req   (remain[f]),
            .ptr   (rr_ptr),
            .idx   (pick_idx[f]),
            .found (found_fu[f])
        );
        assign grant_fu[f]   = found_fu[f] & bus.fu_ready[f];
        assign remain[f+1]   = grant_fu[f] ? (remain[f] & ~(NUM_SLOTS'(1) << pick_idx[f])) : remain[f];
    end

    // The last granting FU holds the furthest slot in round-robin order.
    always_comb begin
        grant_mask = '0;
        rr_next    = rr_ptr;
        for (int unsigned f = 0; f < NUM_FU; f++) begin
            if (grant_fu[f]) begin
                grant_mask[pick_idx[f]] = 1'b1;
                rr_next = (pick_idx[f] == SEL_W'(NUM_SLOTS - 1)) ? '0 : pick_idx[f] + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr          <= '0;
            issue_pend      <= '0;
            alloc_pend      <= '0;
            bus.issue_valid <= '0;
            bus.issue_sel   <= '0;
            bus.slot_issued <= '0;
        end else if (flush) begin
            rr_ptr          <= '0;
            issue_pend      <= '0;
            alloc_pend      <= '0;
            bus.issue_valid <= '0;
            bus.issue_sel   <= '0;
            bus.slot_issued <= '0;
        end else begin
            rr_ptr          <= rr_next;
            issue_pend      <= (issue_pend | grant_mask) & bus.slot_busy;
            alloc_pend      <= (alloc_pend & ~bus.slot_busy) | bus.alloc_wr;
            bus.slot_issued <= grant_mask;
            for (int unsigned f = 0; f < NUM_FU; f++) begin
                bus.issue_valid[f] <= grant_fu[f];
                bus.issue_sel[f]   <= grant_fu[f] ? pick_idx[f] : '0;
            end
        end
    end

`ifdef RS_SCHED_PERF_EN
    logic [32:0] issue_sum, stall_sum;
    logic        stall_now;

    assign issue_sum = {1'b0, perf_issue_cnt} + 33'($countones(bus.issue_valid));
    assign stall_sum = {1'b0, perf_stall_cnt} + 33'd1;
    assign stall_now = (|candidates) & ~(|grant_mask);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else if (flush) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            perf_issue_cnt <= issue_sum[32] ? '1 : issue_sum[31:0];
            if (stall_now) perf_stall_cnt <= stall_sum[32] ? '1 : stall_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed plus randomized check of rs_issue_scheduler against a queue-based scheduling model.
module tb_rs_issue_scheduler;
    import rs_pkg::*;

    localparam int N = 8;
    localparam int F = 4;
    localparam int W = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;

    rs_issue_scheduler_if #(.NUM_SLOTS(N), .NUM_FU(F), .SEL_W(W)) bus ();

`ifdef RS_SCHED_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    rs_issue_scheduler #(.NUM_SLOTS(N), .NUM_FU(F), .SEL_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
`ifdef RS_SCHED_PERF_EN
        ,
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: per-slot pending flags and the round-robin start slot.
    bit m_ipend [N];
    bit m_apend [N];
    int m_rr;

    logic [F-1:0] exp_valid;
    logic [N-1:0] exp_issued;
    int           exp_sel [F];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_ipend[s] = 1'b0;
            m_apend[s] = 1'b0;
        end
        m_rr = 0;
    endtask

    task automatic step(input logic [N-1:0] busy, input logic [N-1:0] ready,
                        input logic dv, input logic [F-1:0] fu, input logic fl);
        int fus[$];
        int cands[$];
        int lowest;
        int n;
        logic [N-1:0] exp_alloc;

        bus.slot_busy      = busy;
        bus.slot_ready     = ready;
        bus.dispatch_valid = dv;
        bus.fu_ready       = fu;
        flush              = fl;
        #1;

        lowest = -1;
        for (int s = 0; s < N; s++)
            if (!busy[s] && !m_apend[s] && lowest < 0) lowest = s;
        chk("dispatch_ready", 32'(bus.dispatch_ready), 32'(lowest >= 0));
        exp_alloc = '0;
        if (dv && lowest >= 0) exp_alloc[lowest] = 1'b1;
        chk("alloc_wr", 32'(bus.alloc_wr), 32'(exp_alloc));

        for (int f = 0; f < F; f++)
            if (fu[f]) fus.push_back(f);
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_rr + k) % N;
            if (busy[s] && ready[s] && !m_ipend[s]) cands.push_back(s);
        end
        n = (fus.size() < cands.size()) ? fus.size() : cands.size();

        exp_valid  = '0;
        exp_issued = '0;
        for (int f = 0; f < F; f++) exp_sel[f] = 0;
        if (!fl) begin
            for (int i = 0; i < n; i++) begin
                exp_valid[fus[i]]   = 1'b1;
                exp_sel[fus[i]]     = cands[i];
                exp_issued[cands[i]] = 1'b1;
            end
        end

        for (int s = 0; s < N; s++) begin
            if (fl) begin
                m_ipend[s] = 1'b0;
                m_apend[s] = 1'b0;
            end else begin
                if (exp_issued[s]) m_ipend[s] = 1'b1;
                else if (!busy[s]) m_ipend[s] = 1'b0;
                if (exp_alloc[s]) m_apend[s] = 1'b1;
                else if (busy[s]) m_apend[s] = 1'b0;
            end
        end
        if (fl) m_rr = 0;
        else if (n > 0) m_rr = (cands[n-1] + 1) % N;

        @(posedge clk);
        #1;
        chk("issue_valid", 32'(bus.issue_valid), 32'(exp_valid));
        chk("slot_issued", 32'(bus.slot_issued), 32'(exp_issued));
        for (int f = 0; f < F; f++)
            if (exp_valid[f]) chk($sformatf("issue_sel%0d", f), 32'(bus.issue_sel[f]), 32'(exp_sel[f]));
    endtask

    initial begin
        int pulses;
        logic [N-1:0] seen;
        logic [N-1:0] rbusy;

        // Reset holds outputs low even with every slot ready.
        bus.slot_busy      = 8'hFF;
        bus.slot_ready     = 8'hFF;
        bus.dispatch_valid = 1'b0;
        bus.fu_ready       = 4'hF;
        reset              = 1'b0;
        model_reset();
        #1;
        chk("reset_issue_valid", 32'(bus.issue_valid), 32'h0);
        chk("reset_slot_issued", 32'(bus.slot_issued), 32'h0);
        @(posedge clk);
        #1;
        chk("reset_issue_valid_edge", 32'(bus.issue_valid), 32'h0);
        chk("reset_issue_sel", 32'(bus.issue_sel), 32'h0);
        chk("reset_dispatch_ready", 32'(bus.dispatch_ready), 32'h0);
        reset = 1'b1;

        // Dispatch with all slots full, then with only slot 3 free.
        step(8'hFF, 8'h00, 1'b1, 4'hF, 1'b0);
        step(8'hF7, 8'h00, 1'b1, 4'hF, 1'b0);
        step(8'hFF, 8'h00, 1'b0, 4'hF, 1'b0);

        // Multi-issue from rr_ptr = 0.
        step(8'hFF, 8'h2D, 1'b0, 4'hF, 1'b0);
        chk("multi_issue_sel", 32'(bus.issue_sel), 32'({3'd5, 3'd3, 3'd2, 3'd0}));
        step(8'h00, 8'h00, 1'b0, 4'h0, 1'b0);

        // Move the pointer to 7, then oversubscribe two FUs with wrap.
        step(8'hFF, 8'h40, 1'b0, 4'h1, 1'b0);
        step(8'h00, 8'h00, 1'b0, 4'h0, 1'b0);
        seen = '0;
        step(8'hFF, 8'hFF, 1'b0, 4'b0101, 1'b0);
        chk("wrap_fu0_sel", 32'(bus.issue_sel[0]), 32'd7);
        chk("wrap_fu2_sel", 32'(bus.issue_sel[2]), 32'd0);
        seen |= bus.slot_issued;
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 8'hFF, 1'b0, 4'b0101, 1'b0);
            seen |= bus.slot_issued;
        end
        chk("oversub_all_issued", 32'(seen), 32'hFF);
        step(8'hFF, 8'hFF, 1'b0, 4'b0101, 1'b0);
        chk("oversub_no_reissue", 32'(bus.slot_issued), 32'h0);
        step(8'h00, 8'h00, 1'b0, 4'h0, 1'b0);

        // No ready FU: nothing issues and the pointer holds.
        step(8'hFF, 8'hFF, 1'b0, 4'h0, 1'b0);
        step(8'hFF, 8'hFF, 1'b0, 4'h1, 1'b0);
        step(8'h00, 8'h00, 1'b0, 4'h0, 1'b0);

        // Slot 4 stays ready until its busy drops; exactly one pulse.
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(8'hFF, 8'h10, 1'b0, 4'hF, 1'b0);
            pulses += int'(bus.slot_issued[4]);
        end
        step(8'hEF, 8'h00, 1'b0, 4'hF, 1'b0);
        pulses += int'(bus.slot_issued[4]);
        chk("single_pulse_slot4", 32'(pulses), 32'd1);

        // Flush in a grant cycle, then confirm pointer restarted at 0.
        step(8'hFF, 8'h03, 1'b0, 4'hF, 1'b1);
        chk("flush_issue_valid", 32'(bus.issue_valid), 32'h0);
        step(8'hFF, 8'h21, 1'b0, 4'h1, 1'b0);
        chk("flush_rr_restart", 32'(bus.issue_sel[0]), 32'd0);

        // Reset asserted between pick and edge discards the grant.
        bus.slot_busy  = 8'hFF;
        bus.slot_ready = 8'hFF;
        bus.fu_ready   = 4'hF;
        flush          = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("midreset_async_valid", 32'(bus.issue_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("midreset_issue_valid", 32'(bus.issue_valid), 32'h0);
        chk("midreset_slot_issued", 32'(bus.slot_issued), 32'h0);
        model_reset();
        reset = 1'b1;
        step(8'hFF, 8'hFF, 1'b0, 4'hF, 1'b0);

        // Randomized traffic with slowly changing occupancy.
        rbusy = 8'h00;
        for (int i = 0; i < 400; i++) begin
            rbusy ^= N'($urandom & $urandom & $urandom);
            step(rbusy, N'($urandom), 1'($urandom), F'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
